// File: rtl/vdic_cmd_alu_if.sv
// Byte-stream handshake and result bus for vdic_cmd_alu.
// The din_parity signal exists only when VDIC_ALU_PARITY_EN is defined.
interface vdic_cmd_alu_if;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] din;
  logic       din_cmd;
  logic       din_last;
`ifdef VDIC_ALU_PARITY_EN
  logic       din_parity;
`endif
  logic [7:0] data1_o;
  logic [7:0] data2_o;
  logic       dout_valid;
  logic       err_o;

  modport master (
`ifdef VDIC_ALU_PARITY_EN
    output din_parity,
`endif
    output din_valid, din, din_cmd, din_last,
    input  din_ready, data1_o, data2_o, dout_valid, err_o
  );

  modport slave (
`ifdef VDIC_ALU_PARITY_EN
    input  din_parity,
`endif
    input  din_valid, din, din_cmd, din_last,
    output din_ready, data1_o, data2_o, dout_valid, err_o
  );
endinterface

// File: rtl/vdic_cmd_alu.sv
// Command-driven byte-stream ALU: folds a frame's data bytes with its command operator.
// Optional feature: define VDIC_ALU_PARITY_EN to check even parity on every frame byte.
module vdic_cmd_alu #(
  parameter int MAX_DATA = 9
) (
  input  logic           clk,
  input  logic           rst,
  vdic_cmd_alu_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_DATA + 1);

  typedef enum logic [7:0] {
    CMD_NOP = 8'h00,
    CMD_AND = 8'h01,
    CMD_OR  = 8'h02,
    CMD_XOR = 8'h03,
    CMD_ADD = 8'h10,
    CMD_SUB = 8'h20
  } command_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESULT
  } state_t;

  state_t           state, state_next;
  logic [7:0]       cmd, cmd_next;
  logic [15:0]      acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err, err_next;
  logic             emit;
  logic             xfer;
  logic             par_err;

  function automatic logic cmd_valid(input logic [7:0] op);
    case (op)
      CMD_NOP, CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB: cmd_valid = 1'b1;
      default:                                             cmd_valid = 1'b0;
    endcase
  endfunction

  // NOP clears the accumulator for every byte, so a single-byte NOP frame yields zero.
  function automatic logic [15:0] alu_fold(input logic [7:0] op, input logic [15:0] a,
                                           input logic [7:0] b, input logic first);
    logic [15:0] bx;
    bx = {8'h00, b};
    if (op == CMD_NOP)  alu_fold = 16'h0000;
    else if (first)     alu_fold = bx;
    else begin
      case (op)
        CMD_AND: alu_fold = a & bx;
        CMD_OR:  alu_fold = a | bx;
        CMD_XOR: alu_fold = a ^ bx;
        CMD_ADD: alu_fold = a + bx;
        CMD_SUB: alu_fold = a - bx;
        default: alu_fold = a;
      endcase
    end
  endfunction

`ifdef VDIC_ALU_PARITY_EN
  assign par_err = ^{bus.din, bus.din_parity};
`else
  assign par_err = 1'b0;
`endif

  assign bus.din_ready = !rst && (state != RESULT);
  assign xfer          = bus.din_valid && bus.din_ready;

  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    acc_next   = acc;
    cnt_next   = cnt;
    err_next   = err;
    emit       = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (xfer) begin
          if (bus.din_cmd) begin
            // A command byte always starts a fresh frame, aborting any open one.
            cmd_next = bus.din;
            acc_next = 16'h0000;
            cnt_next = '0;
            err_next = !cmd_valid(bus.din) || par_err;
            if (bus.din_last) begin
              err_next   = 1'b1;
              emit       = 1'b1;
              state_next = RESULT;
            end else begin
              state_next = COLLECT;
            end
          end else if (state == COLLECT) begin
            err_next = err || par_err;
            if (cnt == CNT_W'(MAX_DATA)) begin
              err_next = 1'b1;
            end else begin
              cnt_next = cnt + CNT_W'(1);
              acc_next = alu_fold(cmd, acc, bus.din, cnt == '0);
            end
            if (bus.din_last) begin
              emit       = 1'b1;
              state_next = RESULT;
            end
          end
        end
      end
      RESULT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd            <= 8'h00;
      acc            <= 16'h0000;
      cnt            <= '0;
      err            <= 1'b0;
      bus.data1_o    <= 8'h00;
      bus.data2_o    <= 8'h00;
      bus.dout_valid <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      state          <= state_next;
      cmd            <= cmd_next;
      acc            <= acc_next;
      cnt            <= cnt_next;
      err            <= err_next;
      bus.dout_valid <= emit;
      if (emit) begin
        {bus.data1_o, bus.data2_o} <= err_next ? 16'hFFFF : acc_next;
        bus.err_o                  <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_vdic_cmd_alu.sv
// Directed testbench for vdic_cmd_alu with hand-computed expected results.
module tb_vdic_cmd_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] frame_q[$];

  vdic_cmd_alu_if bus ();

  vdic_cmd_alu #(.MAX_DATA(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte at the falling edge, wait for ready, hold through one rising edge.
  task automatic xfer(input logic [7:0] d, input logic c, input logic l, input logic bad_par);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.din_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("ready_timeout", 32'd0, 32'd1);
    bus.din_valid = 1'b1;
    bus.din       = d;
    bus.din_cmd   = c;
    bus.din_last  = l;
`ifdef VDIC_ALU_PARITY_EN
    bus.din_parity = (^d) ^ bad_par;
`endif
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din_cmd   = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  // Command byte followed by the bytes in frame_q; checks strobe timing and result.
  task automatic run_frame(input string tag, input logic [7:0] op, input logic [15:0] exp_res,
                           input logic exp_err, input int bad_idx);
    int n;
    n = frame_q.size();
    xfer(op, 1'b1, n == 0, 1'b0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_nostrobe"}, 32'(bus.dout_valid), 32'd0);
      xfer(frame_q[i], 1'b0, i == n - 1, i == bad_idx);
    end
    check({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
    check({tag, "_result"}, {16'h0, bus.data1_o, bus.data2_o}, {16'h0, exp_res});
    check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
    check({tag, "_ready_result"}, 32'(bus.din_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_ready_idle"}, 32'(bus.din_ready), 32'd1);
    check({tag, "_hold"}, {16'h0, bus.data1_o, bus.data2_o}, {16'h0, exp_res});
  endtask

  initial begin
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;
    bus.din_cmd   = 1'b0;
    bus.din_last  = 1'b0;
`ifdef VDIC_ALU_PARITY_EN
    bus.din_parity = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.din_ready), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_data", {16'h0, bus.data1_o, bus.data2_o}, 32'h0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.din_ready), 32'd1);

    // A stray data byte in IDLE is discarded.
    xfer(8'h33, 1'b0, 1'b1, 1'b0);
    check("idle_discard", 32'(bus.dout_valid), 32'd0);

    frame_q = '{8'd10, 8'd20, 8'd30};
    run_frame("add3", 8'h10, 16'h003C, 1'b0, -1);
    frame_q = '{8'd5, 8'd10};
    run_frame("sub", 8'h20, 16'hFFFB, 1'b0, -1);
    frame_q = '{8'h7F};
    run_frame("nop1", 8'h00, 16'h0000, 1'b0, -1);
    frame_q = '{8'hF0, 8'h3C};
    run_frame("and", 8'h01, 16'h0030, 1'b0, -1);

    frame_q = {};
    for (int i = 0; i < 9; i++) frame_q.push_back(8'hFF);
    run_frame("add_max", 8'h10, 16'h08F7, 1'b0, -1);
    frame_q.push_back(8'hFF);
    run_frame("add_over", 8'h10, 16'hFFFF, 1'b1, -1);

    frame_q = '{8'h01};
    run_frame("bad_cmd", 8'h55, 16'hFFFF, 1'b1, -1);
    frame_q = {};
    run_frame("empty", 8'h10, 16'hFFFF, 1'b1, -1);

    // Command mid-frame aborts the open ADD frame silently.
    xfer(8'h10, 1'b1, 1'b0, 1'b0);
    xfer(8'h01, 1'b0, 1'b0, 1'b0);
    frame_q = '{8'h0C, 8'h03};
    run_frame("abort_or", 8'h02, 16'h000F, 1'b0, -1);

    // Reset in the middle of an ADD frame drops it.
    xfer(8'h10, 1'b1, 1'b0, 1'b0);
    xfer(8'h01, 1'b0, 1'b0, 1'b0);
    xfer(8'h02, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.din_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_data", {16'h0, bus.data1_o, bus.data2_o}, 32'h0);
    check("midrst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    xfer(8'h03, 1'b0, 1'b1, 1'b0);
    check("midrst_no_result", 32'(bus.dout_valid), 32'd0);
    frame_q = '{8'hAA, 8'h0F};
    run_frame("xor", 8'h03, 16'h00A5, 1'b0, -1);

`ifdef VDIC_ALU_PARITY_EN
    frame_q = '{8'd1, 8'd2};
    run_frame("parity", 8'h10, 16'hFFFF, 1'b1, 1);
    frame_q = '{8'd1, 8'd2};
    run_frame("parity_ok", 8'h10, 16'h0003, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
